// File: rtl/fifo_arb_mux.sv
// N-channel mux sharing one byte-wide host link: per-client TX FIFOs forwarded as
// headered frames under round-robin arbitration, and RX packets routed by header.
module fifo_arb_mux #(
  parameter int NCH = 4,
  parameter int AW  = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [NCH-1:0]   c_wren,
  input  logic [NCH*8-1:0] c_wrdata,
  input  logic [NCH-1:0]   c_wrlast,
  output logic [NCH-1:0]   c_wrfull,
  input  logic [NCH-1:0]   c_rden,
  output logic [NCH-1:0]   c_rdempty,
  output logic [7:0]       c_rddata,
  output logic             com_wren,
  output logic [7:0]       com_wrdata,
  input  logic             com_wrfull,
  output logic             com_rden,
  input  logic [7:0]       com_rddata,
  input  logic             com_rdempty,
  output logic [1:0]       tx_state,
  output logic [1:0]       rx_state
);

  localparam int DEPTH = 1 << AW;
  localparam int CW    = $clog2(NCH);

  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2} tx_t;
  typedef enum logic [1:0] {RHDR = 2'd0, RPAY = 2'd1, RDROP = 2'd2} rx_t;

  tx_t            ts;
  rx_t            rs;
  logic [NCH-1:0] empty, full, elig, push, pop;
  logic [8:0]     head [NCH];
  logic [CW-1:0]  gnt, rr_ptr, pick, cand;
  logic           pick_ok, tx_fire, rx_av;
  logic [2:0]     rch;
  logic [4:0]     rcnt;

  // Per-channel FIFO of {last, data} plus a count of complete frames it holds.
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [8:0]  mem [DEPTH];
    logic [AW:0] wptr, rptr, fcnt;

    assign full[k]  = (wptr - rptr) == (AW+1)'(DEPTH);
    assign empty[k] = (wptr == rptr);
    assign head[k]  = mem[rptr[AW-1:0]];
    assign push[k]  = c_wren[k] & ~full[k];
    assign elig[k]  = (fcnt != '0) | full[k];

    always_ff @(posedge CLK) begin
      if (push[k]) mem[wptr[AW-1:0]] <= {c_wrlast[k], c_wrdata[8*k +: 8]};
    end

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        wptr <= '0;
        rptr <= '0;
        fcnt <= '0;
      end else begin
        if (push[k]) wptr <= wptr + 1'b1;
        if (pop[k])  rptr <= rptr + 1'b1;
        case ({push[k] & c_wrlast[k], pop[k] & head[k][8]})
          2'b10:   fcnt <= fcnt + 1'b1;
          2'b01:   fcnt <= fcnt - 1'b1;
          default: fcnt <= fcnt;
        endcase
      end
    end
  end

  assign c_wrfull = full;

  // Scan downward so the last hit is the nearest eligible channel after rr_ptr.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    cand    = '0;
    for (int i = NCH; i >= 1; i--) begin
      cand = CW'((int'(rr_ptr) + i) % NCH);
      if (elig[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
    end
  end

  assign tx_fire = (ts == DATA) && !empty[gnt] && !com_wrfull;
  assign pop     = tx_fire ? (NCH'(1) << gnt) : '0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ts     <= IDLE;
      gnt    <= '0;
      rr_ptr <= CW'(NCH - 1);
    end else begin
      case (ts)
        IDLE: if (pick_ok) begin
          gnt    <= pick;
          rr_ptr <= pick;
          ts     <= HDR;
        end
        HDR:  if (!com_wrfull) ts <= DATA;
        DATA: if (tx_fire && head[gnt][8]) ts <= IDLE;
        default: ts <= IDLE;
      endcase
    end
  end

  always_comb begin
    com_wren   = 1'b0;
    com_wrdata = '0;
    if (ts == HDR && !com_wrfull) begin
      com_wren   = 1'b1;
      com_wrdata = {3'(gnt), 5'b00000};
    end else if (tx_fire) begin
      com_wren   = 1'b1;
      com_wrdata = head[gnt][7:0];
    end
  end

  // RX: the header is consumed internally; payload passes straight through.
  assign rx_av = ~com_rdempty;

  always_comb begin
    com_rden  = 1'b0;
    c_rdempty = '1;
    c_rddata  = '0;
    case (rs)
      RHDR:  com_rden = rx_av & ~RESET;
      RPAY: begin
        c_rdempty = ~(NCH'(rx_av) << rch);
        c_rddata  = com_rddata;
        com_rden  = (|(c_rden & (NCH'(1) << rch))) & rx_av;
      end
      RDROP: com_rden = rx_av;
      default: com_rden = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rs   <= RHDR;
      rch  <= '0;
      rcnt <= '0;
    end else begin
      case (rs)
        RHDR: if (rx_av) begin
          rch  <= com_rddata[7:5];
          rcnt <= com_rddata[4:0];
          rs   <= ({1'b0, com_rddata[7:5]} < 4'(NCH)) ? RPAY : RDROP;
        end
        RPAY, RDROP: if (com_rden) begin
          rcnt <= rcnt - 1'b1;
          if (rcnt == 5'd0) rs <= RHDR;
        end
        default: rs <= RHDR;
      endcase
    end
  end

  assign tx_state = ts;
  assign rx_state = rs;

endmodule

// File: tb/tb_fifo_arb_mux.sv
// Bench for fifo_arb_mux: queue-based reference model compared every cycle, directed
// scenarios with literal expectations, then randomized TX/RX traffic.
module tb_fifo_arb_mux;
  localparam int NCH = 4;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic [NCH-1:0] c_wren = '0, c_wrlast = '0, c_rden = '0;
  logic [NCH*8-1:0] c_wrdata = '0;
  logic [NCH-1:0] c_wrfull, c_rdempty;
  logic [7:0] c_rddata, com_wrdata;
  logic [7:0] com_rddata = 8'h00;
  logic com_wren, com_rden;
  logic com_wrfull = 1'b0;
  logic com_rdempty = 1'b1;
  logic [1:0] tx_state, rx_state;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  fifo_arb_mux #(.NCH(NCH), .AW(AW)) dut (
    .CLK(CLK), .RESET(RESET),
    .c_wren(c_wren), .c_wrdata(c_wrdata), .c_wrlast(c_wrlast), .c_wrfull(c_wrfull),
    .c_rden(c_rden), .c_rdempty(c_rdempty), .c_rddata(c_rddata),
    .com_wren(com_wren), .com_wrdata(com_wrdata), .com_wrfull(com_wrfull),
    .com_rden(com_rden), .com_rddata(com_rddata), .com_rdempty(com_rdempty),
    .tx_state(tx_state), .rx_state(rx_state)
  );

  // Reference state: TX client queues, arbitration phase, RX parse mode.
  logic [8:0]  txq [NCH][$];
  int          mph, mg, mrr;
  int          rmode, rchm, rrem;
  logic [7:0]  lrx [$];
  logic [10:0] exp_q [$];
  logic [7:0]  tx_log [$];
  logic [10:0] rx_log [$];
  logic [7:0]  eq [$];
  logic        rden_s = 1'b0;
  int          rem [NCH] = '{default: 0};

  logic           e_wren, e_rden, lav, popm;
  logic [7:0]     e_data;
  logic [NCH-1:0] acc, e_full, e_empty;
  logic [10:0]    exp_v;
  int             found;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit has_frame(input int k);
    bit r = (txq[k].size() == DEPTH);
    for (int i = 0; i < txq[k].size(); i++) if (txq[k][i][8]) r = 1'b1;
    return r;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NCH; k++) txq[k].delete();
    mph = 0; mg = 0; mrr = NCH - 1;
    rmode = 0; rchm = 0; rrem = 0;
  endfunction

  // Compare process: outputs are stable at the falling edge; the model then advances
  // to what the following rising edge must produce.
  always @(negedge CLK) begin
    if (RESET) begin
      model_reset();
      check("rst_com_wren", com_wren, 0);
      check("rst_com_wrdata", com_wrdata, 0);
      check("rst_com_rden", com_rden, 0);
      check("rst_c_wrfull", c_wrfull, 0);
      check("rst_c_rdempty", c_rdempty, 4'hF);
      check("rst_c_rddata", c_rddata, 0);
      rden_s = com_rden;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        acc[k] = c_wren[k] && (txq[k].size() < DEPTH);
        e_full[k] = (txq[k].size() == DEPTH);
      end
      e_wren = 1'b0; e_data = 8'h00; popm = 1'b0;
      if (mph == 1 && !com_wrfull) begin
        e_wren = 1'b1; e_data = {mg[2:0], 5'b00000};
      end else if (mph == 2 && !com_wrfull && txq[mg].size() > 0) begin
        e_wren = 1'b1; e_data = txq[mg][0][7:0]; popm = 1'b1;
      end
      check("com_wren", com_wren, e_wren);
      if (e_wren) check("com_wrdata", com_wrdata, e_data);
      check("c_wrfull", c_wrfull, e_full);
      if (com_wren) tx_log.push_back(com_wrdata);
      case (mph)
        0: begin
          found = -1;
          for (int i = 1; i <= NCH; i++)
            if (found < 0 && has_frame((mrr + i) % NCH)) found = (mrr + i) % NCH;
          if (found >= 0) begin mg = found; mrr = found; mph = 1; end
        end
        1: if (!com_wrfull) mph = 2;
        default: if (popm) begin
          if (txq[mg][0][8]) mph = 0;
          void'(txq[mg].pop_front());
        end
      endcase
      for (int k = 0; k < NCH; k++)
        if (acc[k]) txq[k].push_back({c_wrlast[k], c_wrdata[8*k +: 8]});

      lav = (lrx.size() > 0);
      e_empty = '1; e_rden = 1'b0;
      if (rmode == 0) e_rden = lav;
      else if (rmode == 1) begin e_empty[rchm] = !lav; e_rden = c_rden[rchm] && lav; end
      else e_rden = lav;
      check("com_rden", com_rden, e_rden);
      check("c_rdempty", c_rdempty, e_empty);
      if (rmode == 1 && lav) check("c_rddata", c_rddata, lrx[0]);
      for (int k = 0; k < NCH; k++) begin
        if (c_rden[k] && !c_rdempty[k]) begin
          rx_log.push_back({k[2:0], c_rddata});
          if (exp_q.size() == 0) check("rx_extra_pop", exp_q.size(), 1);
          else begin
            exp_v = exp_q.pop_front();
            check("rx_scoreboard", {k[2:0], c_rddata}, exp_v);
          end
        end
      end
      rden_s = com_rden;
      if (e_rden) begin
        if (rmode == 0) begin
          rchm = lrx[0][7:5]; rrem = lrx[0][4:0];
          rmode = (rchm < NCH) ? 1 : 2;
        end else if (rrem == 0) rmode = 0;
        else rrem--;
      end
    end
  end

  function automatic void link_refresh();
    com_rdempty = (lrx.size() == 0);
    com_rddata = (lrx.size() > 0) ? lrx[0] : 8'h00;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    if (rden_s && lrx.size() > 0) void'(lrx.pop_front());
    c_wren = '0;
    c_wrlast = '0;
    link_refresh();
  endtask

  task automatic wr(input int k, input logic [7:0] b, input logic last);
    c_wren[k] = 1'b1;
    c_wrdata[8*k +: 8] = b;
    c_wrlast[k] = last;
  endtask

  task automatic link_push(input logic [7:0] b);
    lrx.push_back(b);
    link_refresh();
  endtask

  task automatic send_pkt(input int ch, input int len);
    logic [7:0] b;
    link_push({ch[2:0], 5'(len - 1)});
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom());
      link_push(b);
      if (ch < NCH) exp_q.push_back({ch[2:0], b});
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    tx_log.delete();
    rx_log.delete();
  endtask

  task automatic check_log(input string name);
    check({name, "_len"}, tx_log.size(), eq.size());
    for (int i = 0; i < eq.size() && i < tx_log.size(); i++) check(name, tx_log[i], eq[i]);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_tx_state", tx_state, 0);
    check("rst_rx_state", rx_state, 0);
    check("rst_rdempty_lit", c_rdempty, 4'hF);
    RESET = 1'b0;
    tick();

    // Single 3-byte frame on ch1
    tx_log.delete();
    wr(1, 8'h11, 1'b0); tick();
    wr(1, 8'h22, 1'b0); tick();
    wr(1, 8'h33, 1'b1); tick();
    repeat (8) tick();
    eq = '{8'h20, 8'h11, 8'h22, 8'h33};
    check_log("single_frame");
    check("single_idle", tx_state, 0);

    // Round robin from reset pointer: ch0, ch2, ch3 each two 1-byte frames
    do_reset();
    com_wrfull = 1'b1;
    wr(0, 8'h01, 1'b1); wr(2, 8'h02, 1'b1); wr(3, 8'h03, 1'b1); tick();
    wr(0, 8'h04, 1'b1); wr(2, 8'h05, 1'b1); wr(3, 8'h06, 1'b1); tick();
    repeat (2) tick();
    com_wrfull = 1'b0;
    repeat (20) tick();
    eq = '{8'h00, 8'h01, 8'h40, 8'h02, 8'h60, 8'h03, 8'h00, 8'h04, 8'h40, 8'h05, 8'h60, 8'h06};
    check_log("round_robin");

    // Backpressure for 5 cycles mid-frame
    tx_log.delete();
    for (int i = 0; i < 8; i++) begin wr(1, 8'(8'hB0 + i), i == 7); tick(); end
    repeat (3) tick();
    com_wrfull = 1'b1;
    repeat (5) tick();
    com_wrfull = 1'b0;
    repeat (15) tick();
    eq = '{8'h20};
    for (int i = 0; i < 8; i++) eq.push_back(8'(8'hB0 + i));
    check_log("backpressure");

    // RX routing to ch2
    rx_log.delete();
    c_rden = 4'b0100;
    exp_q.push_back(11'h2AA); exp_q.push_back(11'h2BB);
    link_push(8'h41); link_push(8'hAA); link_push(8'hBB);
    repeat (8) tick();
    check("rx_route_len", rx_log.size(), 2);
    if (rx_log.size() == 2) begin
      check("rx_route_b0", rx_log[0], 11'h2AA);
      check("rx_route_b1", rx_log[1], 11'h2BB);
    end
    check("rx_route_state", rx_state, 0);

    // RX drop of nonexistent ch5, then 1 byte to ch0
    rx_log.delete();
    c_rden = 4'b0001;
    exp_q.push_back(11'h055);
    link_push(8'hA2); link_push(8'h01); link_push(8'h02); link_push(8'h03);
    link_push(8'h00); link_push(8'h55);
    repeat (12) tick();
    check("rx_drop_len", rx_log.size(), 1);
    if (rx_log.size() == 1) check("rx_drop_b0", rx_log[0], 11'h055);
    c_rden = '0;

    // Oversize frame: fill ch0 with no last, 17th byte lost, then stream out
    tx_log.delete();
    com_wrfull = 1'b1;
    for (int i = 0; i < 17; i++) begin wr(0, 8'(8'h40 + i), 1'b0); tick(); end
    check("full_flag", c_wrfull, 4'b0001);
    check("full_granted", tx_state, 1);
    com_wrfull = 1'b0;
    repeat (3) tick();
    wr(0, 8'h60, 1'b0); tick();
    wr(0, 8'h61, 1'b0); tick();
    wr(0, 8'h62, 1'b1); tick();
    repeat (25) tick();
    eq = '{8'h00};
    for (int i = 0; i < 16; i++) eq.push_back(8'(8'h40 + i));
    eq.push_back(8'h60); eq.push_back(8'h61); eq.push_back(8'h62);
    check_log("oversize");
    check("oversize_unfull", c_wrfull, 0);

    // Last-byte write coincident with last-byte pop on ch3
    tx_log.delete();
    com_wrfull = 1'b1;
    wr(3, 8'h71, 1'b1); tick();
    tick();
    com_wrfull = 1'b0;
    tick();
    wr(3, 8'h72, 1'b1); tick();
    repeat (10) tick();
    eq = '{8'h60, 8'h71, 8'h60, 8'h72};
    check_log("same_cycle_count");

    // Reset mid-frame
    tx_log.delete();
    for (int i = 0; i < 6; i++) begin wr(2, 8'(8'h81 + i), i == 5); tick(); end
    repeat (3) tick();
    check("pre_rst_wren", com_wren, 1);
    RESET = 1'b1;
    #1;
    check("mid_rst_wren", com_wren, 0);
    tick();
    tick();
    RESET = 1'b0;
    tx_log.delete();
    repeat (12) tick();
    check("post_rst_quiet", tx_log.size(), 0);

    // Randomized traffic on both directions
    for (int cyc = 0; cyc < 3000; cyc++) begin
      com_wrfull = ($urandom_range(0, 3) == 0);
      c_rden = NCH'($urandom());
      for (int k = 0; k < NCH; k++) begin
        if (rem[k] == 0 && $urandom_range(0, 7) == 0) rem[k] = $urandom_range(1, 20);
        if (rem[k] > 0 && $urandom_range(0, 3) != 0) begin
          wr(k, 8'($urandom()), rem[k] == 1);
          rem[k]--;
        end
      end
      if (lrx.size() < 4 && $urandom_range(0, 3) == 0) send_pkt($urandom_range(0, 7), $urandom_range(1, 6));
      tick();
    end
    com_wrfull = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      for (int k = 0; k < NCH; k++)
        if (rem[k] > 0) begin wr(k, 8'($urandom()), rem[k] == 1); rem[k]--; end
      tick();
    end
    c_rden = '1;
    repeat (400) tick();
    check("end_rx_drained", exp_q.size(), 0);
    check("end_link_empty", lrx.size(), 0);
    check("end_tx_state", tx_state, mph);
    check("end_rx_state", rx_state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
